// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/writeback select encodings, branch funct3 codes, defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'd0;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'd64;

    // ALU_LUI passes operand B through; ALU_AUIPC adds operand B to the slot PC.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: 2 async read ports, 1 sync write port, x0 hardwired to zero.
// Latency: reads combinational; write visible next cycle (same cycle when WB_BYPASS_EN is defined).
// Backpressure: none; writes always accepted. Ports: clk, rst_n, i_we/i_waddr/i_wdata, i_raddr1/2 -> o_rdata1/2.
module reg_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the in-flight writeback so decode sees it in the same cycle.
    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 :
                      (i_we && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 :
                      (i_we && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];
`else
    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_regs[i_raddr2];
`endif

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: regfile read, immediate/control decode, in-stage JAL/JALR/branch redirect, ID/EX register.
// Latency: 1 cycle pipe_* -> ex_*; control_j/pc_j combinational. Optional WB_BYPASS_EN forwards writeback.
// Backpressure: none; a slot is squashed (bubble) the cycle after a redirect or when pipe_data == NOP_WORD.
module id_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pipe_pc,
    input  logic [31:0] pipe_pc4,
    input  logic [31:0] pipe_data,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        control_j,
    output logic [31:0] pc_j,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic [1:0]  ex_wb_sel,
    output logic        ex_illegal
);

    logic        r_flush;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_rs1_data, w_rs2_data;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_bubble, w_taken;
    logic [31:0] w_imm;
    alu_op_t     w_alu_op;
    wb_sel_t     w_wb_sel;
    logic        w_alu_src, w_mem_read, w_mem_write, w_reg_write, w_illegal;
    logic        w_is_jal, w_is_jalr, w_is_branch;

    assign w_opcode = pipe_data[6:0];
    assign w_rd     = pipe_data[11:7];
    assign w_funct3 = pipe_data[14:12];
    assign w_rs1    = pipe_data[19:15];
    assign w_rs2    = pipe_data[24:20];

    assign w_imm_i = {{20{pipe_data[31]}}, pipe_data[31:20]};
    assign w_imm_s = {{20{pipe_data[31]}}, pipe_data[31:25], pipe_data[11:7]};
    assign w_imm_b = {{19{pipe_data[31]}}, pipe_data[31], pipe_data[7], pipe_data[30:25], pipe_data[11:8], 1'b0};
    assign w_imm_u = {pipe_data[31:12], 12'd0};
    assign w_imm_j = {{11{pipe_data[31]}}, pipe_data[31], pipe_data[19:12], pipe_data[20], pipe_data[30:21], 1'b0};

    // The slot right after a redirect is wrong-path fetch and must not take effect.
    assign w_bubble = (pipe_data == NOP_WORD) || r_flush;

    reg_file u_reg_file (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_we     (wb_en),
        .i_waddr  (wb_rd),
        .i_wdata  (wb_data),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rs1_data),
        .o_rdata2 (w_rs2_data)
    );

    always_comb begin
        w_alu_op    = ALU_ADD;
        w_wb_sel    = WB_ALU;
        w_alu_src   = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        w_imm       = '0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;
        w_is_branch = 1'b0;
        case (w_opcode)
            OPC_OP, OPC_OP_IMM: begin
                w_reg_write = 1'b1;
                w_alu_src   = (w_opcode == OPC_OP_IMM);
                w_imm       = (w_opcode == OPC_OP_IMM) ? w_imm_i : 32'd0;
                case (w_funct3)
                    3'd0: w_alu_op = ((w_opcode == OPC_OP) && pipe_data[30]) ? ALU_SUB : ALU_ADD;
                    3'd1: w_alu_op = ALU_SLL;
                    3'd2: w_alu_op = ALU_SLT;
                    3'd3: w_alu_op = ALU_SLTU;
                    3'd4: w_alu_op = ALU_XOR;
                    3'd5: w_alu_op = pipe_data[30] ? ALU_SRA : ALU_SRL;
                    3'd6: w_alu_op = ALU_OR;
                    default: w_alu_op = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
                w_alu_src   = 1'b1;
                w_wb_sel    = WB_MEM;
                w_imm       = w_imm_i;
            end
            OPC_STORE: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
                w_imm       = w_imm_s;
            end
            OPC_BRANCH: begin
                w_is_branch = 1'b1;
                w_imm       = w_imm_b;
            end
            OPC_JAL: begin
                w_is_jal    = 1'b1;
                w_reg_write = 1'b1;
                w_wb_sel    = WB_PC4;
                w_imm       = w_imm_j;
            end
            OPC_JALR: begin
                w_is_jalr   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_wb_sel    = WB_PC4;
                w_imm       = w_imm_i;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_op    = (w_opcode == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
                w_imm       = w_imm_u;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            F3_BEQ:  w_taken = (w_rs1_data == w_rs2_data);
            F3_BNE:  w_taken = (w_rs1_data != w_rs2_data);
            F3_BLT:  w_taken = ($signed(w_rs1_data) <  $signed(w_rs2_data));
            F3_BGE:  w_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
            F3_BLTU: w_taken = (w_rs1_data <  w_rs2_data);
            F3_BGEU: w_taken = (w_rs1_data >= w_rs2_data);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        control_j = 1'b0;
        pc_j      = pipe_pc4;
        if (!w_bubble) begin
            if (w_is_jal) begin
                control_j = 1'b1;
                pc_j      = pipe_pc + w_imm_j;
            end else if (w_is_jalr) begin
                control_j = 1'b1;
                pc_j      = (w_rs1_data + w_imm_i) & ~32'd1;
            end else if (w_is_branch && w_taken) begin
                control_j = 1'b1;
                pc_j      = pipe_pc + w_imm_b;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush      <= 1'b0;
            ex_valid     <= 1'b0;
            ex_pc        <= RESET_PC;
            ex_pc4       <= RESET_PC + 32'd4;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_funct3    <= '0;
            ex_alu_op    <= '0;
            ex_alu_src   <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_wb_sel    <= '0;
            ex_illegal   <= 1'b0;
        end else begin
            r_flush      <= control_j;
            ex_valid     <= !w_bubble;
            ex_pc        <= pipe_pc;
            ex_pc4       <= pipe_pc4;
            ex_rs1_data  <= w_rs1_data;
            ex_rs2_data  <= w_rs2_data;
            ex_imm       <= w_imm;
            ex_rd        <= w_rd;
            ex_funct3    <= w_funct3;
            ex_alu_op    <= w_alu_op;
            ex_alu_src   <= w_alu_src;
            ex_mem_read  <= w_mem_read  && !w_bubble;
            ex_mem_write <= w_mem_write && !w_bubble;
            ex_reg_write <= w_reg_write && !w_bubble;
            ex_wb_sel    <= w_wb_sel;
            ex_illegal   <= w_illegal   && !w_bubble;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: reset, regfile, immediates, redirect/squash, branches, bypass, illegal.
// Latency: checks ex_* one cycle after presenting a slot, control_j/pc_j in the same cycle.
// Backpressure: n/a.
module tb_id_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pipe_pc, pipe_pc4, pipe_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        control_j;
    logic [31:0] pc_j;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_pc4, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [1:0]  ex_wb_sel;
    logic        ex_illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset_n(reset_n), .pipe_pc(pipe_pc), .pipe_pc4(pipe_pc4), .pipe_data(pipe_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .control_j(control_j), .pc_j(pc_j),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_wb_sel(ex_wb_sel),
        .ex_illegal(ex_illegal)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] word);
        pipe_pc   = pc;
        pipe_pc4  = pc + 32'd4;
        pipe_data = word;
    endtask

    // Writes one register through the writeback port while ID holds a bubble (also clears any pending squash).
    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        present(32'h0, 32'h0);
        wb_en = 1'b1; wb_rd = rd; wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        present(32'h0, 32'h00500093);
        tick(); tick();
        checks++; if (ex_pc !== 32'd64) begin errors++; $display("FAIL reset_ex_pc got=%h exp=%h", ex_pc, 32'd64); end
        checks++; if (ex_pc4 !== 32'd68) begin errors++; $display("FAIL reset_ex_pc4 got=%h exp=%h", ex_pc4, 32'd68); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got=%b exp=0", ex_reg_write); end
        reset_n = 1'b1;
        tick();
        checks++; if (ex_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got=%0d exp=1", ex_rd); end
        checks++; if (ex_imm !== 32'd5) begin errors++; $display("FAIL addi_imm got=%h exp=5", ex_imm); end
        checks++; if (ex_alu_src !== 1'b1) begin errors++; $display("FAIL addi_alu_src got=%b exp=1", ex_alu_src); end
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b exp=1", ex_valid); end
        checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL addi_reg_write got=%b exp=1", ex_reg_write); end
    endtask

    task automatic test_regfile();
        wb_write(5'd5, 32'h1234);
        present(32'h100, enc_r(7'd0, 5'd0, 5'd5, 3'd0, 5'd3, 7'h33));
        tick();
        checks++; if (ex_rs1_data !== 32'h1234) begin errors++; $display("FAIL add_rs1 got=%h exp=%h", ex_rs1_data, 32'h1234); end
        checks++; if (ex_alu_op !== ALU_ADD) begin errors++; $display("FAIL add_alu_op got=%0d exp=%0d", ex_alu_op, ALU_ADD); end
        checks++; if (ex_alu_src !== 1'b0) begin errors++; $display("FAIL add_alu_src got=%b exp=0", ex_alu_src); end
        present(32'h104, enc_r(7'h20, 5'd5, 5'd0, 3'd0, 5'd3, 7'h33));
        tick();
        checks++; if (ex_rs2_data !== 32'h1234) begin errors++; $display("FAIL sub_rs2 got=%h exp=%h", ex_rs2_data, 32'h1234); end
        checks++; if (ex_alu_op !== ALU_SUB) begin errors++; $display("FAIL sub_alu_op got=%0d exp=%0d", ex_alu_op, ALU_SUB); end
        wb_write(5'd0, 32'd7);
        present(32'h108, enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd3, 7'h33));
        tick();
        checks++; if (ex_rs1_data !== 32'd0) begin errors++; $display("FAIL x0_read got=%h exp=0", ex_rs1_data); end
        present(32'h10C, enc_i(12'd8, 5'd5, 3'd2, 5'd4, 7'h03));
        tick();
        checks++; if (ex_mem_read !== 1'b1 || ex_wb_sel !== 2'd1 || ex_imm !== 32'd8 || ex_funct3 !== 3'd2)
            begin errors++; $display("FAIL lw_ctrl got=%b/%0d/%h/%0d exp=1/1/8/2", ex_mem_read, ex_wb_sel, ex_imm, ex_funct3); end
        present(32'h110, enc_s(12'hFFC, 5'd5, 5'd0, 3'd2));
        tick();
        checks++; if (ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0 || ex_imm !== 32'hFFFFFFFC)
            begin errors++; $display("FAIL sw_ctrl got=%b/%b/%h exp=1/0/fffffffc", ex_mem_write, ex_reg_write, ex_imm); end
    endtask

    task automatic test_jal_squash();
        present(32'h80, enc_j(21'd16, 5'd1));
        #1;
        checks++; if (control_j !== 1'b1 || pc_j !== 32'h90) begin errors++; $display("FAIL jal_redirect got=%b/%h exp=1/90", control_j, pc_j); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_wb_sel !== 2'd2 || ex_pc4 !== 32'h84 || ex_imm !== 32'd16)
            begin errors++; $display("FAIL jal_slot got=%b/%0d/%h/%h exp=1/2/84/10", ex_valid, ex_wb_sel, ex_pc4, ex_imm); end
        // Second jump back-to-back lands in the squashed slot.
        present(32'h84, enc_j(21'd16, 5'd1));
        #1;
        checks++; if (control_j !== 1'b0 || pc_j !== 32'h88) begin errors++; $display("FAIL squash_no_redirect got=%b/%h exp=0/88", control_j, pc_j); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL squash_slot got=%b/%b exp=0/0", ex_valid, ex_reg_write); end
        present(32'h90, 32'h00500093);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h90) begin errors++; $display("FAIL after_squash got=%b/%h exp=1/90", ex_valid, ex_pc); end
    endtask

    task automatic test_jalr_branch();
        wb_write(5'd6, 32'h100);
        present(32'h200, enc_i(12'd3, 5'd6, 3'd0, 5'd0, 7'h67));
        #1;
        checks++; if (control_j !== 1'b1 || pc_j !== 32'h102) begin errors++; $display("FAIL jalr_target got=%b/%h exp=1/102", control_j, pc_j); end
        tick();
        present(32'h0, 32'h0);
        tick();
        present(32'h40, enc_b(13'h1FF8, 5'd0, 5'd0, F3_BEQ));
        #1;
        checks++; if (control_j !== 1'b1 || pc_j !== 32'h38) begin errors++; $display("FAIL beq_target got=%b/%h exp=1/38", control_j, pc_j); end
        tick();
        checks++; if (ex_imm !== 32'hFFFFFFF8 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL beq_slot got=%h/%b exp=fffffff8/0", ex_imm, ex_reg_write); end
        present(32'h0, 32'h0);
        tick();
        present(32'h40, enc_b(13'h1FF8, 5'd0, 5'd0, F3_BNE));
        #1;
        checks++; if (control_j !== 1'b0 || pc_j !== 32'h44) begin errors++; $display("FAIL bne_not_taken got=%b/%h exp=0/44", control_j, pc_j); end
        tick();
    endtask

    task automatic test_signed_branch();
        wb_write(5'd7, 32'hFFFFFFFF);
        wb_write(5'd8, 32'd1);
        present(32'h100, enc_b(13'd32, 5'd8, 5'd7, F3_BLT));
        #1;
        checks++; if (control_j !== 1'b1 || pc_j !== 32'h120) begin errors++; $display("FAIL blt_taken got=%b/%h exp=1/120", control_j, pc_j); end
        tick();
        present(32'h0, 32'h0);
        tick();
        present(32'h100, enc_b(13'd32, 5'd8, 5'd7, F3_BLTU));
        #1;
        checks++; if (control_j !== 1'b0 || pc_j !== 32'h104) begin errors++; $display("FAIL bltu_not_taken got=%b/%h exp=0/104", control_j, pc_j); end
        present(32'h100, enc_b(13'd32, 5'd8, 5'd7, F3_BGE));
        #1;
        checks++; if (control_j !== 1'b0) begin errors++; $display("FAIL bge_not_taken got=%b exp=0", control_j); end
        present(32'h100, enc_b(13'd32, 5'd8, 5'd7, F3_BGEU));
        #1;
        checks++; if (control_j !== 1'b1 || pc_j !== 32'h120) begin errors++; $display("FAIL bgeu_taken got=%b/%h exp=1/120", control_j, pc_j); end
        tick();
        present(32'h0, 32'h0);
        tick();
    endtask

    task automatic test_bypass_illegal();
        logic [31:0] exp_same;
        wb_write(5'd9, 32'h55);
`ifdef WB_BYPASS_EN
        exp_same = 32'hAA;
`else
        exp_same = 32'h55;
`endif
        wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'hAA;
        present(32'h300, enc_r(7'd0, 5'd0, 5'd9, 3'd0, 5'd2, 7'h33));
        tick();
        wb_en = 1'b0;
        checks++; if (ex_rs1_data !== exp_same) begin errors++; $display("FAIL same_cycle_wb got=%h exp=%h", ex_rs1_data, exp_same); end
        tick();
        checks++; if (ex_rs1_data !== 32'hAA) begin errors++; $display("FAIL next_cycle_wb got=%h exp=aa", ex_rs1_data); end
        present(32'h304, 32'h0000007F);
        #1;
        checks++; if (control_j !== 1'b0) begin errors++; $display("FAIL illegal_redirect got=%b exp=0", control_j); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0)
            begin errors++; $display("FAIL illegal_slot got=%b%b%b%b%b exp=11000", ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write); end
    endtask

    task automatic test_async_reset();
        present(32'h400, 32'h00500093);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'd64 || ex_pc4 !== 32'd68)
            begin errors++; $display("FAIL async_reset got=%b/%h/%h exp=0/40/44", ex_valid, ex_pc, ex_pc4); end
        reset_n = 1'b1;
        present(32'h404, enc_r(7'd0, 5'd0, 5'd5, 3'd0, 5'd3, 7'h33));
        tick();
        checks++; if (ex_rs1_data !== 32'd0 || ex_valid !== 1'b1) begin errors++; $display("FAIL regfile_cleared got=%h/%b exp=0/1", ex_rs1_data, ex_valid); end
    endtask

    initial begin
        test_reset();
        test_regfile();
        test_jal_squash();
        test_jalr_branch();
        test_signed_branch();
        test_bypass_illegal();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
